// File: rtl/otter_pkg.sv
// Shared OTTER definitions: divide/remainder opcodes, divider state encoding and
// the special-case result constants.
package otter_pkg;

    localparam logic [1:0] DIV_OP  = 2'b00;
    localparam logic [1:0] DIVU_OP = 2'b01;
    localparam logic [1:0] REM_OP  = 2'b10;
    localparam logic [1:0] REMU_OP = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } div_state_t;

    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift {rem,quo} left, trial-subtract the
// divisor from the upper WIDTH+1 bits, keep or restore.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted - {1'b0, divisor};
        // shifted < 2*divisor, so the restore path always has shifted[WIDTH]=0
        if (!trial[WIDTH]) begin
            rem_next = trial[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/otter_divider.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit: restoring divide on magnitudes
// followed by a sign-fixup cycle, with a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; operands latched on acceptance
// CALC  | one shift/trial-subtract iteration per cycle, WIDTH cycles
// FIX   | apply signs or special-case values, write result
// DONE  | done pulse for one cycle, then back to IDLE
module otter_divider
    import otter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       div_fun,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [CW-1:0]    count_q, count_d;
    logic [1:0]       fun_q, fun_d;
    logic             quo_neg_q, quo_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             special_q, special_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] step_rem, step_quo;
    logic             in_signed, is_rem;
    logic [WIDTH-1:0] a_mag, b_mag;

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (divisor_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    always_comb begin
        in_signed = (div_fun == DIV_OP) || (div_fun == REM_OP);
        a_mag     = (in_signed && A[WIDTH-1]) ? -A : A;
        b_mag     = (in_signed && B[WIDTH-1]) ? -B : B;
        is_rem    = (fun_q == REM_OP) || (fun_q == REMU_OP);

        state_d   = state_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        count_d   = count_q;
        fun_d     = fun_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        special_d = special_q;
        result_d  = result_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    fun_d     = div_fun;
                    divisor_d = b_mag;
                    quo_neg_d = in_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                    rem_neg_d = in_signed && A[WIDTH-1];
                    rem_d     = '0;
                    count_d   = '0;
                    busy_d    = 1'b1;
                    if ((B == '0) || (in_signed && (A == INT_MIN) && (B == DIV_ZERO_Q))) begin
                        // raw A is kept in quo so REM/REMU by zero can return it
                        special_d = 1'b1;
                        quo_d     = A;
                        state_d   = ST_FIX;
                    end else begin
                        special_d = 1'b0;
                        quo_d     = a_mag;
                        state_d   = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                rem_d   = step_rem;
                quo_d   = step_quo;
                count_d = count_q + 1'b1;
                busy_d  = 1'b1;
                if (count_q == LAST_ITER) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (special_q) begin
                    // a zero stored magnitude means divide-by-zero, else overflow
                    if (divisor_q == '0) begin
                        result_d = is_rem ? quo_q : DIV_ZERO_Q;
                    end else begin
                        result_d = is_rem ? '0 : INT_MIN;
                    end
                end else if (is_rem) begin
                    result_d = rem_neg_q ? -rem_q : rem_q;
                end else begin
                    result_d = quo_neg_q ? -quo_q : quo_q;
                end
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            count_q   <= '0;
            fun_q     <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            special_q <= 1'b0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            count_q   <= count_d;
            fun_q     <= fun_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            special_q <= special_d;
            result_q  <= result_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
